// File: rtl/rv32e_pkg.sv
// Shared RV32E definitions: load funct3 encodings, load FSM states and
// small decode helpers used by the load path.
package rv32e_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WB    = 2'd2,
    FAULT = 2'd3
  } load_state_t;

  // Number of bytes fetched for a legal load.
  function automatic logic [2:0] load_bytes(input logic [2:0] f3);
    case (f3)
      F3_LW:          load_bytes = 3'd4;
      F3_LH, F3_LHU:  load_bytes = 3'd2;
      default:        load_bytes = 3'd1;
    endcase
  endfunction

  // True for illegal encodings and for misaligned halfword/word loads.
  function automatic logic load_reject(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_LB, F3_LBU: load_reject = 1'b0;
      F3_LH, F3_LHU: load_reject = addr_lo[0];
      F3_LW:         load_reject = |addr_lo;
      default:       load_reject = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of the assembled little-endian load buffer.
module load_extend
  import rv32e_pkg::*;
(
  input  logic [31:0] data_buf,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  always_comb begin
    value = data_buf;
    case (funct3)
      F3_LB:   value = {{24{data_buf[7]}}, data_buf[7:0]};
      F3_LH:   value = {{16{data_buf[15]}}, data_buf[15:0]};
      F3_LBU:  value = {24'd0, data_buf[7:0]};
      F3_LHU:  value = {16'd0, data_buf[15:0]};
      default: value = data_buf;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Byte-serial load engine: fetches 1/2/4 bytes over a req/ack port,
// assembles them little-endian and issues one register-file write.
module load_unit
  import rv32e_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [3:0]        rd,
  output logic              ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [3:0]        write_register,
  output logic [31:0]       write_value,
  output logic              wr_en,
  output logic              done,
  output logic              err
);

  load_state_t        state_reg, state_next;
  logic [ADDR_W-1:0]  addr_reg;
  logic [2:0]         funct3_reg;
  logic [3:0]         rd_reg;
  logic [2:0]         count_reg;
  logic [31:0]        buf_reg;
  logic [31:0]        buf_next;
  logic [31:0]        value_reg;
  logic [3:0]         wreg_reg;
  logic [31:0]        ext_value;
  logic [3:0]         lane_we;
  logic               accept;
  logic               byte_taken;
  logic               last_ack;

  assign byte_taken = (state_reg == READ) && mem_ack;

  // One write enable per byte lane, selected by the running byte count.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = byte_taken && (count_reg[1:0] == 2'(gi));
      assign buf_next[gi*8 +: 8] = lane_we[gi] ? mem_rdata : buf_reg[gi*8 +: 8];
    end
  endgenerate

  // Extension sees the buffer including the byte arriving on the final ack,
  // so the result can be registered on entry to WB.
  load_extend u_extend (
    .data_buf (buf_next),
    .funct3   (funct3_reg),
    .value    (ext_value)
  );

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last_ack   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = load_reject(funct3, addr[1:0]) ? FAULT : READ;
        end
      end
      READ: begin
        if (mem_ack && (count_reg == load_bytes(funct3_reg) - 3'd1)) begin
          last_ack   = 1'b1;
          state_next = WB;
        end
      end
      WB:      state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      funct3_reg <= '0;
      rd_reg     <= '0;
      count_reg  <= '0;
      buf_reg    <= '0;
      value_reg  <= '0;
      wreg_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg   <= addr;
        funct3_reg <= funct3;
        rd_reg     <= rd;
        count_reg  <= '0;
        buf_reg    <= '0;
      end else if (byte_taken) begin
        count_reg <= count_reg + 3'd1;
        buf_reg   <= buf_next;
      end
      if (last_ack) begin
        value_reg <= ext_value;
        wreg_reg  <= rd_reg;
      end
    end
  end

  // Alignment was checked on accept, so the offset never carries out of bit 1.
  assign mem_addr       = {addr_reg[ADDR_W-1:2], addr_reg[1:0] + count_reg[1:0]};
  assign mem_req        = (state_reg == READ);
  assign ready          = (state_reg == IDLE);
  assign done           = (state_reg == WB) || (state_reg == FAULT);
  assign err            = (state_reg == FAULT);
  assign wr_en          = (state_reg == WB) && (rd_reg != 4'd0);
  assign write_register = wreg_reg;
  assign write_value    = value_reg;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: a memory responder with configurable wait
// states, and a scoreboard monitor that checks every done/wr_en pulse.
module tb_load_unit;
  import rv32e_pkg::*;

  localparam int ADDR_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        funct3;
  logic [3:0]        rd;
  logic              ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [3:0]        write_register;
  logic [31:0]       write_value;
  logic              wr_en;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  load_unit #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .addr           (addr),
    .funct3         (funct3),
    .rd             (rd),
    .ready          (ready),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .write_register (write_register),
    .write_value    (write_value),
    .wr_en          (wr_en),
    .done           (done),
    .err            (err)
  );

  typedef struct packed {
    logic        e_err;
    logic        e_wr;
    logic [3:0]  e_rd;
    logic [31:0] e_val;
  } exp_t;

  exp_t              sb_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  logic [7:0]        mem_bytes [int];
  int                mem_wait;
  int                ack_count;
  int                n_checks;
  int                n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: decides ack for the current cycle at the falling edge.
  initial begin : mem_model
    int                wcnt;
    logic              waiting_prev;
    logic [ADDR_W-1:0] prev_addr;
    logic [ADDR_W-1:0] exp_a;
    wcnt = 0;
    waiting_prev = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        if (waiting_prev) chk("mem_addr_hold", 32'(mem_addr), 32'(prev_addr));
        if (wcnt >= mem_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_bytes.exists(int'(mem_addr)) ? mem_bytes[int'(mem_addr)] : 8'h00;
          wcnt      = 0;
          ack_count++;
          waiting_prev = 1'b0;
          if (addr_q.size() == 0) begin
            chk("unexpected_mem_req", 32'(mem_req), 32'd0);
          end else begin
            exp_a = addr_q.pop_front();
            chk("mem_addr", 32'(mem_addr), 32'(exp_a));
          end
        end else begin
          mem_ack      = 1'b0;
          wcnt++;
          waiting_prev = 1'b1;
          prev_addr    = mem_addr;
        end
      end else begin
        mem_ack      = 1'b0;
        wcnt         = 0;
        waiting_prev = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every done pulse consumes one expected response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_en && !done) chk("wr_en_without_done", 32'(wr_en), 32'd0);
      if (err && !done)   chk("err_without_done", 32'(err), 32'd0);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("err", 32'(err), 32'(e.e_err));
          chk("wr_en", 32'(wr_en), 32'(e.e_wr));
          if (e.e_wr) begin
            chk("write_register", 32'(write_register), 32'(e.e_rd));
            chk("write_value", write_value, e.e_val);
          end
          $display("txn: done err=%0b wr_en=%0b reg=%0d value=0x%08h", err, wr_en,
                   write_register, write_value);
        end
      end
    end
  end

  // Issue one load and check latency, traffic and the return of ready.
  task automatic run_load(input logic [ADDR_W-1:0] a, input logic [2:0] f3,
                          input logic [3:0] r, input int w, input logic exp_err,
                          input logic [31:0] exp_val, input int pulse_cyc);
    int   cyc;
    int   acks0;
    int   nb;
    int   exp_lat;
    exp_t e;
    cyc = 0;
    while (!ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_before_start", 32'(ready), 32'd1);
    nb = exp_err ? 0 : int'(load_bytes(f3));
    exp_lat = exp_err ? 1 : nb * (w + 1) + 1;
    mem_wait = w;
    acks0 = ack_count;
    e.e_err = exp_err;
    e.e_wr  = !exp_err && (r != 4'd0);
    e.e_rd  = r;
    e.e_val = exp_val;
    sb_q.push_back(e);
    for (int i = 0; i < nb; i++) addr_q.push_back(a + ADDR_W'(i));
    start = 1'b1; addr = a; funct3 = f3; rd = r;
    @(posedge clk);
    #1;
    start = 1'b0; addr = 24'hABCDEF; funct3 = 3'b011; rd = 4'hF;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (exp_err && cyc == 1) chk("fault_no_mem_req", 32'(mem_req), 32'd0);
      if (pulse_cyc != 0 && cyc == pulse_cyc) begin
        start = 1'b1; addr = 24'h000500; funct3 = F3_LB; rd = 4'd7;
      end else begin
        start = 1'b0;
      end
    end while (!done && cyc < 200);
    start = 1'b0;
    chk("done_latency", 32'(cyc), 32'(exp_lat));
    chk("ack_count", 32'(ack_count - acks0), 32'(nb));
    @(negedge clk);
    chk("ready_after_done", 32'(ready), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int acks0;
    n_checks = 0; n_fail = 0; ack_count = 0; mem_wait = 0;
    rst = 1'b1; start = 1'b0; addr = '0; funct3 = '0; rd = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    mem_bytes[32'h100] = 8'h78; mem_bytes[32'h101] = 8'h56;
    mem_bytes[32'h102] = 8'h34; mem_bytes[32'h103] = 8'h12;
    mem_bytes[32'h203] = 8'h80;
    mem_bytes[32'h010] = 8'hFF; mem_bytes[32'h011] = 8'h80;
    mem_bytes[32'h300] = 8'h11; mem_bytes[32'h301] = 8'h22;
    mem_bytes[32'h302] = 8'h33; mem_bytes[32'h303] = 8'h44;
    mem_bytes[32'h400] = 8'hEF; mem_bytes[32'h401] = 8'hBE;
    mem_bytes[32'h402] = 8'hAD; mem_bytes[32'h403] = 8'hDE;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_write_value", write_value, 32'd0);
    chk("reset_write_register", 32'(write_register), 32'd0);

    // Main function: widths, extension and wait states.
    run_load(24'h000100, F3_LW,  4'd5, 0, 1'b0, 32'h12345678, 0);
    run_load(24'h000203, F3_LB,  4'd3, 0, 1'b0, 32'hFFFFFF80, 0);
    run_load(24'h000203, F3_LBU, 4'd4, 0, 1'b0, 32'h00000080, 0);
    run_load(24'h000010, F3_LH,  4'd6, 3, 1'b0, 32'hFFFF80FF, 0);
    run_load(24'h000010, F3_LHU, 4'd9, 3, 1'b0, 32'h000080FF, 0);

    // Rejections.
    run_load(24'h000011, F3_LH,  4'd2, 0, 1'b1, 32'h0, 0);
    run_load(24'h000102, F3_LW,  4'd2, 0, 1'b1, 32'h0, 0);
    run_load(24'h000100, 3'b011, 4'd2, 0, 1'b1, 32'h0, 0);

    // Reset after two acked bytes of an LW.
    mem_wait = 0;
    acks0 = ack_count;
    addr_q.push_back(24'h000300);
    addr_q.push_back(24'h000301);
    start = 1'b1; addr = 24'h000300; funct3 = F3_LW; rd = 4'd8;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("txn: reset during LW after %0d bytes", ack_count - acks0);
    chk("reset_mid_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mid_ready", 32'(ready), 32'd1);
    chk("reset_mid_acks", 32'(ack_count - acks0), 32'd2);
    run_load(24'h000300, F3_LW, 4'd8, 0, 1'b0, 32'h44332211, 0);

    // rd=0 suppresses the write; a start pulse mid-READ is ignored.
    run_load(24'h000400, F3_LW, 4'd0, 1, 1'b0, 32'hDEADBEEF, 3);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    chk("addr_queue_empty", 32'(addr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_unit.md
# load_unit

Byte-serial load engine for the RV32E core, sitting directly upstream of the register file's write port. It accepts one decoded load (address, funct3, destination register), fetches 1, 2 or 4 bytes over a byte-wide request/acknowledge memory port, and assembles them little-endian. It applies sign or zero extension and drives a single-cycle register-file write (`write_register`, `write_value`, `wr_en`). Misaligned or illegal loads are rejected with `err` and no memory traffic.

## Interface
- `ADDR_W`, 24: byte address width of the memory port.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: load request; accepted only when `ready`=1.
- `addr` in ADDR_W: byte address, captured on accept.
- `funct3` in 3: load type, captured on accept.
  - 000 = LB
  - 001 = LH
  - 010 = LW
  - 100 = LBU
  - 101 = LHU
  - other values are illegal.
- `rd` in 4: destination register, captured on accept.
- `ready` out 1: high only in IDLE.
- `mem_req` out 1: byte read request; held until acknowledged.
- `mem_addr` out ADDR_W: byte address, stable while `mem_req`=1 and not acked.
- `mem_ack` in 1: `mem_rdata` is valid this cycle for the current request.
- `mem_rdata` in 8: read byte.
- `write_register` out 4: register-file destination.
- `write_value` out 32: extended load result.
- `wr_en` out 1: one-cycle write strobe.
- `done` out 1: one-cycle completion pulse, for both success and error.
- `err` out 1: one-cycle pulse with `done` on misaligned or illegal load.

## Operation
- Reset values: `ready`=1 (state IDLE); all other outputs and internal registers are 0.
- **States**
  - IDLE: waits for `start`.
  - READ: issues byte requests.
  - WB: performs the register-file write.
  - FAULT: reports a rejected load.
- **Accept.** In IDLE with `start`=1:
  - Latch `addr`, `funct3` and `rd`; clear the byte count and data buffer.
  - Go to FAULT if `funct3` is illegal, if LH/LHU has `addr[0]`=1, or if LW has `addr[1:0]`≠0.
  - Otherwise go to READ.
- **Byte count.** N = 1 for LB/LBU, 2 for LH/LHU, 4 for LW.
- **READ**
  - `mem_req`=1 and `mem_addr` = latched addr + byte count.
  - Only the low 2 bits change; alignment guarantees no carry and no wrap.
  - On `mem_ack`=1, store `mem_rdata` into buffer lane [count] and increment count.
  - Stay in READ until the Nth ack, then go to WB.
- **WB.** Lasts one cycle.
  - `done`=1.
  - `wr_en`=1 unless latched `rd`=0; `write_register` = latched `rd`.
  - Then go to IDLE.
- **Extension.**
  - LB: sign bit is `buf[7]`.
  - LH: sign bit is `buf[15]`.
  - LBU/LHU: zero-extend.
  - LW: the 32-bit buffer passes through unchanged.
- **FAULT.** Lasts one cycle: `done`=1 and `err`=1; no `mem_req`, no `wr_en`. Then go to IDLE.
- **Ignored events**
  - `start` outside IDLE.
  - `mem_ack` while `mem_req`=0.
  - Input changes after accept.
- **Reset mid-operation.** `rst` in any state returns the block to IDLE at that edge.
  - `mem_req` is low the next cycle; no `wr_en`, `done` or `err` is produced.
  - The memory side must tolerate an abandoned request.
- `write_value` and `write_register` hold their last value outside WB; they are meaningful only when `wr_en`=1.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- `start` is accepted at edge c0.
  - First `mem_req` is visible in cycle c1.
  - Zero-wait memory (ack in the same cycle as req): one byte per cycle.
  - `wr_en`/`done` fire in cycle c0+N+1.
  - `ready` returns in cycle c0+N+2.
- Each wait cycle (`mem_req`=1, `mem_ack`=0) adds one cycle of latency. `mem_addr` is held during waits.
- After an ack, `mem_addr` advances in the next cycle and `mem_req` stays high without a gap.
- Fault path: `err`/`done` in cycle c1, `ready` in cycle c2.
- Back-to-back: a new `start` is accepted in the first cycle `ready`=1.

## Structure
- Shared package `rv32e_pkg`:
  - Load funct3 constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - Typedef `load_state_t` enumerating {IDLE, READ, WB, FAULT}.
- One sub-module: `load_extend`, combinational. Inputs are the 32-bit buffer and funct3; output is the 32-bit extended value.
- The FSM, byte counter and buffer stay in `load_unit`.

## Test plan
- LW, `addr`=0x000100, `rd`=5, zero-wait, bytes 0x78, 0x56, 0x34, 0x12 -> `mem_addr` 0x100..0x103 in c1..c4; `wr_en` in c5 with `write_register`=5 and `write_value`=0x12345678.
- LB, `addr`=0x000203, byte 0x80 -> 0xFFFFFF80. LBU with the same inputs -> 0x00000080.
- LH, `addr`=0x000010, 3 wait cycles per byte, bytes 0xFF, 0x80 -> `mem_addr` held during waits; `write_value`=0xFFFF80FF. LHU with the same inputs -> 0x000080FF.
- Each rejection case (LH `addr`=0x000011, LW `addr`=0x000102, `funct3`=011) -> `err`=1 and `done`=1 in c1; `mem_req` and `wr_en` stay 0; `ready`=1 in c2.
- `rst` asserted after 2 acked bytes of an LW -> `mem_req`=0 and `ready`=1 in the next cycle; no `wr_en`. A following LW returns its correct value.
- LW with `rd`=0 -> 4 memory reads and a `done` pulse; `wr_en` stays 0. `start` pulsed mid-READ is ignored.
